// File: rtl/mux_scan_pkg.sv
// Shared types and reset values for the mux scan sequencer.
// Optional feature macro: SCAN_PARITY_EN (adds the PAR output).
package mux_scan_pkg;

    // Sequencer states; DONE state drives the DONE output for one cycle
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } scan_state_e;

    // Reset values of the single-bit outputs
    localparam logic RST_NEN  = 1'b1;
    localparam logic RST_BUSY = 1'b0;
    localparam logic RST_DONE = 1'b0;
    localparam logic RST_PAR  = 1'b1;

endpackage

// File: rtl/scan_sel_counter.sv
// Select counter for the scan sequencer: clear, count-enable, terminal-count flag.
module scan_sel_counter #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] sel,
    output logic         tc_c
);

    // Count up while enabled; clear has priority; wraps naturally at 2**W-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel <= '0;
        end else if (clr) begin
            sel <= '0;
        end else if (en) begin
            sel <= sel + W'(1);
        end
    end

    // Terminal count: the last select value of a scan
    assign tc_c = (sel == {W{1'b1}});

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps an N:1 mux select through every input and assembles the sampled
// B bits into a parallel word Q.
// Optional feature macro: SCAN_PARITY_EN (registered odd-parity output PAR).
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int unsigned SEL_BITS = 3
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      START,
    input  logic                      ABORT,
    input  logic                      B,
    output logic [SEL_BITS-1:0]       SEL,
    output logic                      nEN,
    output logic [(2**SEL_BITS)-1:0]  Q,
    output logic                      BUSY,
    output logic                      DONE
`ifdef SCAN_PARITY_EN
    ,
    output logic                      PAR
`endif
);

    localparam int unsigned N = 2 ** SEL_BITS;

    scan_state_e   state;
    logic [N-1:0]  asm_word;
    logic [N-1:0]  word_c;
    logic          cnt_clr_c;
    logic          cnt_en_c;
    logic          tc_c;

    // Counter runs only in SCAN; leaving SCAN (or aborting) returns SEL to 0
    assign cnt_en_c  = (state == S_SCAN);
    assign cnt_clr_c = (state != S_SCAN) || ABORT;

    scan_sel_counter #(
        .W (SEL_BITS)
    ) u_sel_counter (
        .clk  (CLK),
        .rst  (RST),
        .clr  (cnt_clr_c),
        .en   (cnt_en_c),
        .sel  (SEL),
        .tc_c (tc_c)
    );

    // Completed word: last bit comes straight from B on the final capture edge
    assign word_c = {B, asm_word[N-2:0]};

    // Sequencer FSM, assembly register and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            nEN      <= RST_NEN;
            BUSY     <= RST_BUSY;
            DONE     <= RST_DONE;
            Q        <= '0;
            asm_word <= '0;
`ifdef SCAN_PARITY_EN
            PAR      <= RST_PAR;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        state    <= S_SCAN;
                        nEN      <= 1'b0;
                        BUSY     <= 1'b1;
                        asm_word <= '0;
                    end
                end
                S_SCAN: begin
                    if (ABORT) begin
                        state <= S_IDLE;
                        nEN   <= 1'b1;
                        BUSY  <= 1'b0;
                    end else begin
                        asm_word[SEL] <= B;
                        if (tc_c) begin
                            state <= S_DONE;
                            nEN   <= 1'b1;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            Q     <= word_c;
`ifdef SCAN_PARITY_EN
                            PAR   <= ~^word_c;
`endif
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    DONE  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    nEN   <= 1'b1;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: table of directed scans plus hand-written
// sequences for held START and asynchronous reset mid-scan.
// PAR checks are compiled in when SCAN_PARITY_EN is defined.
module tb_mux_scan_sequencer;

    logic       CLK;
    logic       RST;
    logic       START;
    logic       ABORT;
    logic       B;
    logic [2:0] SEL;
    logic       nEN;
    logic [7:0] Q;
    logic       BUSY;
    logic       DONE;
`ifdef SCAN_PARITY_EN
    logic       PAR;
`endif
    logic [7:0] D;

    int n_vec;
    int n_fail;

    mux_scan_sequencer #(.SEL_BITS(3)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .ABORT (ABORT),
        .B     (B),
        .SEL   (SEL),
        .nEN   (nEN),
        .Q     (Q),
        .BUSY  (BUSY),
        .DONE  (DONE)
`ifdef SCAN_PARITY_EN
        ,
        .PAR   (PAR)
`endif
    );

    // Mux model: selected data bit, gated by the active-low strobe
    assign B = D[SEL] & ~nEN;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] d;
        int         abort_sel;   // -1: no abort
        logic [7:0] q;           // expected Q after the scan
        logic       par;         // expected PAR after the scan
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_par(input string name, input logic exp);
`ifdef SCAN_PARITY_EN
        chk(name, 8'(PAR), 8'(exp));
`else
        if (exp === 1'bx) $display("unused %s", name);
`endif
    endtask

    // One scan from IDLE, optionally aborted when SEL reaches abort_sel
    task automatic run_scan(input vec_t v);
        D     = v.d;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("scan_nen", 8'(nEN), 8'd0);
        chk("scan_busy", 8'(BUSY), 8'd1);
        for (int i = 0; i < 8; i++) begin
            chk("scan_sel", 8'(SEL), 8'(i));
            if (i == v.abort_sel) begin
                ABORT = 1'b1;
                tick();
                ABORT = 1'b0;
                chk("abort_nen", 8'(nEN), 8'd1);
                chk("abort_sel0", 8'(SEL), 8'd0);
                chk("abort_busy", 8'(BUSY), 8'd0);
                chk("abort_done", 8'(DONE), 8'd0);
                tick();
                chk("abort_done2", 8'(DONE), 8'd0);
                chk("abort_q", Q, v.q);
                chk_par("abort_par", v.par);
                return;
            end
            tick();
        end
        chk("done_pulse", 8'(DONE), 8'd1);
        chk("done_q", Q, v.q);
        chk("done_busy", 8'(BUSY), 8'd0);
        chk("done_nen", 8'(nEN), 8'd1);
        chk("done_sel", 8'(SEL), 8'd0);
        chk_par("done_par", v.par);
        tick();
        chk("done_end", 8'(DONE), 8'd0);
        chk("idle_q", Q, v.q);
    endtask

    initial begin
        int done_at[$];

        n_vec  = 0;
        n_fail = 0;
        RST    = 1'b1;
        START  = 1'b0;
        ABORT  = 1'b0;
        D      = 8'h00;

        vecs[0] = '{d: 8'hA5, abort_sel: -1, q: 8'hA5, par: 1'b1};
        vecs[1] = '{d: 8'h3C, abort_sel:  3, q: 8'hA5, par: 1'b1};
        vecs[2] = '{d: 8'h3C, abort_sel: -1, q: 8'h3C, par: 1'b1};
        vecs[3] = '{d: 8'h0F, abort_sel:  7, q: 8'h3C, par: 1'b1};
        vecs[4] = '{d: 8'h01, abort_sel: -1, q: 8'h01, par: 1'b0};
        vecs[5] = '{d: 8'h03, abort_sel: -1, q: 8'h03, par: 1'b1};
        vecs[6] = '{d: 8'h5A, abort_sel:  0, q: 8'h03, par: 1'b1};
        vecs[7] = '{d: 8'h80, abort_sel: -1, q: 8'h80, par: 1'b0};

        // Reset state
        #12;
        chk("rst_sel", 8'(SEL), 8'd0);
        chk("rst_nen", 8'(nEN), 8'd1);
        chk("rst_q", Q, 8'h00);
        chk("rst_busy", 8'(BUSY), 8'd0);
        chk("rst_done", 8'(DONE), 8'd0);
        chk_par("rst_par", 1'b1);
        RST = 1'b0;
        tick();

        // ABORT and START-free idle: nothing happens
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("idle_abort_nen", 8'(nEN), 8'd1);
        chk("idle_abort_busy", 8'(BUSY), 8'd0);

        // Directed table
        for (int v = 0; v < 8; v++) begin
            run_scan(vecs[v]);
        end

        // START held high: back-to-back scans every 10 cycles
        D     = 8'hFF;
        START = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (DONE) done_at.push_back(c);
            if (c == 29) START = 1'b0;
        end
        chk("held_count", 8'(done_at.size()), 8'd3);
        if (done_at.size() == 3) begin
            chk("held_first", 8'(done_at[0]), 8'd9);
            chk("held_gap1", 8'(done_at[1] - done_at[0]), 8'd10);
            chk("held_gap2", 8'(done_at[2] - done_at[1]), 8'd10);
        end
        chk("held_q", Q, 8'hFF);
        chk_par("held_par", 1'b1);
        tick();
        chk("held_stop_busy", 8'(BUSY), 8'd0);

        // Async reset mid-scan at SEL=5
        D     = 8'hC3;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_rst_sel", 8'(SEL), 8'd5);
        #2;
        RST = 1'b1;
        #1;
        chk("mid_rst_sel", 8'(SEL), 8'd0);
        chk("mid_rst_nen", 8'(nEN), 8'd1);
        chk("mid_rst_q", Q, 8'h00);
        chk("mid_rst_busy", 8'(BUSY), 8'd0);
        chk_par("mid_rst_par", 1'b1);
        #1;
        RST = 1'b0;
        tick();
        run_scan('{d: 8'h81, abort_sel: -1, q: 8'h81, par: 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
